fifo_pop_ctrl: RTL and testbench
================================

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 10, the FIFO word width in bits.
REQ-002 The block SHALL have parameter MAIN_SIZE, default 8, the depth of the attached FIFO in words, for documentation and bench sizing only.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  pop enable from the switch scheduler.
REQ-006 The block SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 The block SHALL have port fifo_error  input  1  FIFO overflow/underflow error flag.
REQ-008 The block SHALL have port data_out_pop  input  DATA_SIZE  FIFO read data, valid the cycle after read is sampled high.
REQ-009 The block SHALL have port dest_pause  input  1  downstream almost-full backpressure.
REQ-010 The block SHALL have port err_clr  input  1  single-cycle request to leave ERROR.
REQ-011 The block SHALL have port read  output  1  FIFO pop strobe, combinational.
REQ-012 The block SHALL have port data_out  output  DATA_SIZE  registered word delivered downstream.
REQ-013 The block SHALL have port valid_out  output  1  one-cycle qualifier for data_out.
REQ-014 The block SHALL have port ctrl_error  output  1  high while in ERROR.
REQ-015 The block SHALL have port idle  output  1  high in IDLE with no word in flight.
REQ-016 The block SHALL have port pop_count  output  8  count of words delivered.

Function
REQ-017 The FSM SHALL have states IDLE, POP and ERROR.
REQ-018 IDLE SHALL go to POP when en=1 and fifo_empty=0.
REQ-019 POP SHALL go to IDLE when en=0 or fifo_empty=1.
REQ-020 Any state SHALL go to ERROR when fifo_error=1 is sampled; this has priority over every other transition.
REQ-021 ERROR SHALL go to IDLE on err_clr=1 with fifo_error=0; err_clr outside ERROR SHALL be ignored.
REQ-022 read SHALL equal (state==POP) AND !fifo_empty AND !dest_pause AND !fifo_error AND en.
REQ-023 read SHALL therefore drop in the same cycle that dest_pause, fifo_empty, fifo_error or en=0 appears.
REQ-024 A read sampled at edge N SHALL set an in-flight flag; at edge N+1 data_out SHALL load data_out_pop.
REQ-025 valid_out SHALL be high for exactly the cycle following edge N+1, giving 2-cycle read-to-valid latency, one valid_out pulse per read and ordering preserved.
REQ-026 Back-to-back reads SHALL yield back-to-back valid_out pulses, sustaining 1 word/cycle.
REQ-027 Words already in flight when dest_pause rises SHALL still be delivered, so downstream must absorb up to 2 words after pausing.
REQ-028 Entering ERROR SHALL clear the in-flight flag and suppress valid_out; in-flight words are discarded.
REQ-029 data_out SHALL hold its last value when valid_out=0.
REQ-030 ctrl_error SHALL equal (state==ERROR).
REQ-031 idle SHALL equal (state==IDLE) AND no in-flight word AND valid_out=0.
REQ-032 The block SHALL never assert read while fifo_empty=1, so it cannot cause an underflow.

Reset
REQ-033 reset=1 SHALL immediately force: state IDLE, read 0, data_out 0, valid_out 0, in-flight flag 0, ctrl_error 0, idle 1, pop_count 0.
REQ-034 reset asserted mid-burst SHALL drop read combinationally and discard in-flight words.
REQ-035 The first read after reset release SHALL occur no earlier than the cycle after the IDLE-to-POP edge.

Configuration
REQ-036 Macro POP_COUNT_EN defined: pop_count SHALL increment by 1 on each valid_out pulse, wrapping 255 to 0, and SHALL be held in ERROR.
REQ-037 Macro POP_COUNT_EN undefined: the pop_count port SHALL remain and be constant 0, with no counter logic.

Verification
REQ-038 FIFO model preloaded with 'h3,'h4,'h5, en=1, dest_pause=0 -> read high 3 consecutive cycles; valid_out pulses carry 'h3,'h4,'h5, each 2 cycles after its read; FSM returns to IDLE; pop_count=3 with POP_COUNT_EN.
REQ-039 FIFO holds 8 words; dest_pause raised after the 2nd read cycle for 4 cycles -> read low those 4 cycles; exactly 2 words delivered before the gap; all 8 delivered in order; no underflow.
REQ-040 fifo_error pulsed during a burst -> read low the same cycle; ctrl_error=1; no valid_out for in-flight words; err_clr returns to IDLE and popping resumes on the next word.
REQ-041 reset pulsed mid-burst -> read, valid_out and pop_count are 0 immediately; idle=1.
REQ-042 Deliver 256 words with POP_COUNT_EN -> pop_count wraps to 0; same run without the macro -> pop_count stays 0 throughout.

Source files
------------

// File: rtl/fifo_pop_ctrl.sv
// FIFO pop controller: pops words while enabled, honours downstream pause and
// delivers each word on a registered data_out/valid_out pair. Optional macro POP_COUNT_EN adds a delivered-word counter.
module fifo_pop_ctrl #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic                 fifo_error,
  input  logic [DATA_SIZE-1:0] data_out_pop,
  input  logic                 dest_pause,
  input  logic                 err_clr,
  output logic                 read,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 ctrl_error,
  output logic                 idle,
  output logic [7:0]           pop_count
);

  // state   | meaning
  // S_IDLE  | not popping, waiting for en with a non-empty FIFO
  // S_POP   | popping whenever the FIFO has data and downstream is not paused
  // S_ERROR | FIFO reported an error; waits for err_clr
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t state;
  logic   in_flight;
  logic   load;

  if (MAIN_SIZE < 1) begin : g_bad_depth
    $error("fifo_pop_ctrl: MAIN_SIZE must be at least 1");
  end

  assign read = (state == S_POP) & ~fifo_empty & ~dest_pause & ~fifo_error & en;

  // A word popped last cycle is only delivered if no error arrives meanwhile.
  assign load = in_flight & ~fifo_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      in_flight <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      in_flight <= read;
      valid_out <= load;
      if (load)
        data_out <= data_out_pop;

      if (fifo_error) begin
        state <= S_ERROR;
      end else begin
        case (state)
          S_IDLE:  if (en && !fifo_empty) state <= S_POP;
          S_POP:   if (!en || fifo_empty) state <= S_IDLE;
          S_ERROR: if (err_clr)           state <= S_IDLE;
          default:                        state <= S_IDLE;
        endcase
      end
    end
  end

  assign ctrl_error = (state == S_ERROR);
  assign idle       = (state == S_IDLE) & ~in_flight & ~valid_out;

`ifdef POP_COUNT_EN
  logic [7:0] count_q;

  // Counts at the edge that raises valid_out; load is never set in S_ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= 8'd0;
    else if (load)
      count_q <= count_q + 8'd1;
  end

  assign pop_count = count_q;
`else
  assign pop_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: a queue-based FIFO and a delivery schedule predict
// read, valid_out/data_out timing, idle, ctrl_error and pop_count.
module tb_fifo_pop_ctrl;

  localparam int DW = 10;
  localparam int M_IDLE = 0;
  localparam int M_POP  = 1;
  localparam int M_ERR  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, fifo_empty, fifo_error, dest_pause, err_clr;
  logic [DW-1:0] data_out_pop;
  logic          read, valid_out, ctrl_error, idle;
  logic [DW-1:0] data_out;
  logic [7:0]    pop_count;

  fifo_pop_ctrl #(.DATA_SIZE(DW), .MAIN_SIZE(8)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
    .fifo_error(fifo_error), .data_out_pop(data_out_pop),
    .dest_pause(dest_pause), .err_clr(err_clr), .read(read),
    .data_out(data_out), .valid_out(valid_out), .ctrl_error(ctrl_error),
    .idle(idle), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] w;
  } delivery_t;

  logic [DW-1:0] fifo_q[$];
  delivery_t     sched[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            m_mode = M_IDLE;
  int            cnt_m = 0;
  int            n_rd = 0;
  int            n_vo = 0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] pop_w = '0;
  bit            pop_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef POP_COUNT_EN
    return cnt_m;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check read, advance model.
  task automatic cycle(input bit en_i, input bit pause_i, input bit err_i, input bit clr_i);
    bit            exp_v, exp_rd;
    logic [DW-1:0] word;
    @(negedge clk);
    exp_v = (sched.size() > 0) && (sched[0].due == cyc);
    check("valid_out", valid_out, exp_v);
    if (valid_out) n_vo++;
    if (exp_v) begin
      exp_data = sched[0].w;
      void'(sched.pop_front());
      cnt_m = (cnt_m + 1) % 256;
    end
    check("data_out", data_out, exp_data);
    check("ctrl_error", ctrl_error, m_mode == M_ERR);
    check("idle", idle, (m_mode == M_IDLE) && !exp_v && (sched.size() == 0));
    if (!exp_v) check("pop_count", pop_count, exp_count());

    en = en_i; dest_pause = pause_i; fifo_error = err_i; err_clr = clr_i;
    fifo_empty = (fifo_q.size() == 0);
    data_out_pop = pop_v ? pop_w : DW'($urandom);
    #1;
    exp_rd = (m_mode == M_POP) && !fifo_empty && !pause_i && !err_i && en_i;
    check("read", read, exp_rd);
    check("no_underflow", read & fifo_empty, 0);
    if (read) n_rd++;

    pop_v = 1'b0;
    if (exp_rd) begin
      word = fifo_q.pop_front();
      sched.push_back('{due: cyc + 2, w: word});
      pop_w = word;
      pop_v = 1'b1;
    end
    if (err_i) begin
      sched.delete();
      m_mode = M_ERR;
    end else begin
      case (m_mode)
        M_IDLE: if (en_i && !fifo_empty) m_mode = M_POP;
        M_POP:  if (!en_i || fifo_empty) m_mode = M_IDLE;
        default: if (clr_i) m_mode = M_IDLE;
      endcase
    end
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases after one edge.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_read", read, 0);
    check("rst_valid", valid_out, 0);
    check("rst_count", pop_count, 0);
    check("rst_idle", idle, 1);
    check("rst_error", ctrl_error, 0);
    check("rst_data", data_out, 0);
    @(posedge clk);
    #2;
    en = 1'b0; fifo_error = 1'b0; err_clr = 1'b0; dest_pause = 1'b0;
    reset = 1'b0;
    sched.delete();
    m_mode = M_IDLE; cnt_m = 0; exp_data = '0; pop_v = 1'b0;
  endtask

  initial begin
    en = 1'b0; fifo_empty = 1'b1; fifo_error = 1'b0; dest_pause = 1'b0;
    err_clr = 1'b0; data_out_pop = '0;
    reset = 1'b1;
    #3;
    check("init_read", read, 0);
    check("init_idle", idle, 1);
    check("init_valid", valid_out, 0);
    check("init_count", pop_count, 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Three-word burst
    fifo_q = '{10'h3, 10'h4, 10'h5};
    n_rd = 0;
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
    check("burst_reads", n_rd, 3);
    check("burst_idle", idle, 1);
`ifdef POP_COUNT_EN
    check("burst_count", pop_count, 3);
`else
    check("burst_count", pop_count, 0);
`endif

    // Eight words with a four-cycle pause after the second read
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(10'h100 + i));
    n_rd = 0;
    for (int i = 0; i < 16; i++) cycle(1, (i >= 3) && (i <= 6), 0, 0);
    check("pause_reads", n_rd, 8);

    // Error mid-burst, then clear and resume
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(10'h200 + i));
    for (int i = 0; i < 14; i++) cycle(1, 0, i == 3, i == 6);

    // Reset mid-burst
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(10'h300 + i));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    pulse_reset();
    fifo_q.delete();

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(1, 0) == 1) fifo_q.push_back(DW'($urandom));
      cycle($urandom_range(99, 0) < 80, $urandom_range(99, 0) < 20,
            $urandom_range(99, 0) < 2, $urandom_range(99, 0) < 30);
    end

    // 256 deliveries: counter wraps back to zero
    pulse_reset();
    fifo_q.delete();
    n_vo = 0;
    for (int i = 0, pushed = 0; i < 300; i++) begin
      if (pushed < 256 && fifo_q.size() < 8) begin
        fifo_q.push_back(DW'($urandom));
        pushed++;
      end
      cycle(1, 0, 0, 0);
    end
    check("wrap_delivered", n_vo, 256);
    check("wrap_count", pop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
